// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_e;

  localparam int DEF_N_BTN            = 2;
  localparam int DEF_TICK_DIV         = 250000;
  localparam int DEF_DEB_TICKS        = 8;
  localparam int DEF_RPT_DELAY_TICKS  = 2000;
  localparam int DEF_RPT_PERIOD_TICKS = 400;
  localparam int DEF_RPT_EN           = 1;

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw levels in, conditioned levels, strobes and debug state out.
interface button_conditioner_if #(
  parameter int N_BTN = 2
);
  // Handshake: press_pulse is a one-clk strobe with no back-pressure; the
  // consumer must act on it in the single cycle it is high.
  logic [N_BTN-1:0]      btn_in;
  logic [N_BTN-1:0]      btn_level;
  logic [N_BTN-1:0]      press_pulse;
  logic                  tick;
  logic [N_BTN-1:0][1:0] chan_state;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, tick, chan_state
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, tick, chan_state
  );
endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, tick-driven integrator with hysteresis,
// and the IDLE/HOLD/REPEAT pulse FSM with its repeat counter.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEB_TICKS        = DEF_DEB_TICKS,
  parameter int RPT_DELAY_TICKS  = DEF_RPT_DELAY_TICKS,
  parameter int RPT_PERIOD_TICKS = DEF_RPT_PERIOD_TICKS,
  parameter int RPT_EN           = DEF_RPT_EN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  input  logic       tick_i,
  input  logic       others_held_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic [1:0] state_o
);

  localparam int IC_W   = $clog2(DEB_TICKS + 1);
  localparam int RC_MAX = (RPT_DELAY_TICKS > RPT_PERIOD_TICKS) ? RPT_DELAY_TICKS : RPT_PERIOD_TICKS;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  localparam logic [IC_W-1:0] IC_FULL    = IC_W'(DEB_TICKS);
  localparam logic [RC_W-1:0] RC_DLY_END = RC_W'(RPT_DELAY_TICKS - 1);
  localparam logic [RC_W-1:0] RC_PER_END = RC_W'(RPT_PERIOD_TICKS - 1);

  logic            sync1_q, sync2_q;
  logic [IC_W-1:0] ic_q, ic_d;
  logic            level_q, level_d;
  logic [RC_W-1:0] rc_q;
  logic            pulse_q;
  logic            rpt_ok;
  chan_state_e     state_q;

  always_comb begin
    ic_d = ic_q;
    if (tick_i) begin
      if (sync2_q) begin
        if (ic_q != IC_FULL) ic_d = ic_q + IC_W'(1);
      end else if (ic_q != '0) begin
        ic_d = ic_q - IC_W'(1);
      end
    end
    // Level only flips at the rails, so mid-range chatter never reaches the FSM.
    level_d = level_q;
    if (ic_d == IC_FULL)  level_d = 1'b1;
    else if (ic_d == '0)  level_d = 1'b0;
  end

  assign rpt_ok = (RPT_EN != 0) && !others_held_i;

  // The FSM reacts to level_d so a press pulse lands the clk right after its tick.
  // At a terminal count rc wraps even when the repeat is suppressed, keeping phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      ic_q    <= '0;
      level_q <= 1'b0;
      rc_q    <= '0;
      pulse_q <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      ic_q    <= ic_d;
      level_q <= level_d;
      pulse_q <= 1'b0;
      if (!level_d) begin
        state_q <= ST_IDLE;
        rc_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_HOLD;
            rc_q    <= '0;
            pulse_q <= 1'b1;
          end
          ST_HOLD: begin
            if (tick_i) begin
              if (rc_q == RC_DLY_END) begin
                rc_q    <= '0;
                state_q <= ST_REPEAT;
                pulse_q <= rpt_ok;
              end else begin
                rc_q <= rc_q + RC_W'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (tick_i) begin
              if (rc_q == RC_PER_END) begin
                rc_q    <= '0;
                pulse_q <= rpt_ok;
              end else begin
                rc_q <= rc_q + RC_W'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign state_o = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: shared sample-tick prescaler feeding N_BTN debounce channels.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN            = DEF_N_BTN,
  parameter int TICK_DIV         = DEF_TICK_DIV,
  parameter int DEB_TICKS        = DEF_DEB_TICKS,
  parameter int RPT_DELAY_TICKS  = DEF_RPT_DELAY_TICKS,
  parameter int RPT_PERIOD_TICKS = DEF_RPT_PERIOD_TICKS,
  parameter int RPT_EN           = DEF_RPT_EN
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave bus
);

  localparam int TD_W = $clog2(TICK_DIV);
  localparam logic [TD_W-1:0] DIV_END = TD_W'(TICK_DIV - 1);

  logic [TD_W-1:0]       div_q, div_d;
  logic                  tick;
  logic [N_BTN-1:0]      others_held;
  logic [N_BTN-1:0]      level_w;
  logic [N_BTN-1:0]      pulse_w;
  logic [N_BTN-1:0][1:0] state_w;

  assign tick = (div_q == DIV_END);

  always_comb begin
    div_d = div_q + TD_W'(1);
    if (tick) div_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    assign others_held[g] = |(level_w & ~(N_BTN'(1) << g));

    btn_channel #(
      .DEB_TICKS       (DEB_TICKS),
      .RPT_DELAY_TICKS (RPT_DELAY_TICKS),
      .RPT_PERIOD_TICKS(RPT_PERIOD_TICKS),
      .RPT_EN          (RPT_EN)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_i        (bus.btn_in[g]),
      .tick_i       (tick),
      .others_held_i(others_held[g]),
      .level_o      (level_w[g]),
      .pulse_o      (pulse_w[g]),
      .state_o      (state_w[g])
    );
  end

  assign bus.tick        = tick;
  assign bus.btn_level   = level_w;
  assign bus.press_pulse = pulse_w;
  assign bus.chan_state  = state_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a repeat-enabled and a repeat-disabled instance,
// pulse scoreboard with timing windows, plus level and reset checks.
module tb_button_conditioner;

  localparam int TD     = 4;
  localparam int DEB    = 3;
  localparam int DLY    = 5;
  localparam int PER    = 2;
  localparam int LAT_LO = (DEB - 1) * TD + 3;
  localparam int LAT_HI = DEB * TD + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   stim_cyc = 0;
  int   last_pulse_cyc = 0;
  int   rise_cnt[4];
  logic [3:0] lvl_prev = '0;

  // {from_stim[20], lo[19:12], hi[11:4], vec[3:0]}
  logic [20:0] exp_q[$];

  button_conditioner_if #(.N_BTN(2)) bus();
  button_conditioner_if #(.N_BTN(2)) bus_nr();

  button_conditioner #(
    .N_BTN(2), .TICK_DIV(TD), .DEB_TICKS(DEB),
    .RPT_DELAY_TICKS(DLY), .RPT_PERIOD_TICKS(PER), .RPT_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  button_conditioner #(
    .N_BTN(2), .TICK_DIV(TD), .DEB_TICKS(DEB),
    .RPT_DELAY_TICKS(DLY), .RPT_PERIOD_TICKS(PER), .RPT_EN(0)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .bus(bus_nr)
  );

  logic [3:0] lvl_all, pulse_all;
  assign lvl_all   = {bus_nr.btn_level, bus.btn_level};
  assign pulse_all = {bus_nr.press_pulse, bus.press_pulse};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] vec, input int lo, input int hi, input logic from_stim);
    exp_q.push_back({from_stim, 8'(lo), 8'(hi), vec});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [20:0] it;
    int d, lo, hi;
    for (int i = 0; i < 4; i++)
      if (lvl_all[i] && !lvl_prev[i]) rise_cnt[i]++;
    lvl_prev = lvl_all;
    if (pulse_all != 4'd0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", 32'(pulse_all), 32'd0);
      end else begin
        it = exp_q.pop_front();
        lo = int'(it[19:12]);
        hi = int'(it[11:4]);
        d  = cyc - (it[20] ? stim_cyc : last_pulse_cyc);
        check_eq("pulse_vec", 32'(pulse_all), 32'(it[3:0]));
        check_eq($sformatf("pulse_dly d=%0d window=%0d..%0d", d, lo, hi),
                 32'((d >= lo) && (d <= hi)), 32'd1);
      end
      last_pulse_cyc = cyc;
    end
  end

  // ---------------- driver / wait tasks ----------------
  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_low(input int idx, input string tag);
    int n = 0;
    #1;
    while (lvl_all[idx] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq($sformatf("%s n=%0d", tag, n), 32'(!lvl_all[idx] && (n <= LAT_HI)), 32'd1);
  endtask

  task automatic wait_tick_neg(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick && n < 20);
    if (!bus.tick) check_eq(tag, 32'(bus.tick), 32'd1);
  endtask

  task automatic drive_at_edge(input int which, input logic [1:0] val);
    @(posedge clk);
    #1;
    if (which == 0) bus.btn_in = val;
    else            bus_nr.btn_in = val;
    stim_cyc = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, r0, r1;
    for (int i = 0; i < 4; i++) rise_cnt[i] = 0;
    bus.btn_in    = '0;
    bus_nr.btn_in = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_level", 32'(lvl_all), 32'd0);
    check_eq("rst_pulse", 32'(pulse_all), 32'd0);
    check_eq("rst_tick", 32'(bus.tick), 32'd0);
    check_eq("rst_state", 32'(bus.chan_state), 32'd0);
    rst_n = 1'b1;

    // Prescaler: one-clk tick every TD clks.
    wait_tick_neg("tick_first");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick && n < 10);
    check_eq("tick_period", 32'(n), 32'(TD));

    // 1: stable press with auto-repeat, then one trailing repeat inside release latency.
    drive_at_edge(0, 2'b01);
    push_exp(4'b0001, LAT_LO, LAT_HI, 1'b1);
    push_exp(4'b0001, DLY * TD, DLY * TD, 1'b0);
    repeat (3) push_exp(4'b0001, PER * TD, PER * TD, 1'b0);
    wait_drain(100, "s1_hold_drain");
    check_eq("s1_state_repeat", 32'(bus.chan_state[0]), 32'd2);
    #1;
    bus.btn_in = 2'b00;
    push_exp(4'b0001, PER * TD, PER * TD, 1'b0);
    wait_drain(20, "s1_tail_drain");
    wait_low(0, "s1_release");
    repeat (10) @(posedge clk);

    // 2: chatter aligned so every tick samples the low phase, then stable high.
    r0 = rise_cnt[0];
    wait_tick_neg("s2_align");
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      bus.btn_in[0] = ((i % 2) == 0);
      @(posedge clk);
      #1;
    end
    check_eq("s2_no_level_in_chatter", 32'(rise_cnt[0] - r0), 32'd0);
    bus.btn_in[0] = 1'b1;
    stim_cyc = cyc;
    push_exp(4'b0001, LAT_LO, LAT_HI, 1'b1);
    wait_drain(30, "s2_drain");
    #1;
    bus.btn_in[0] = 1'b0;
    wait_low(0, "s2_release");
    check_eq("s2_single_level_rise", 32'(rise_cnt[0] - r0), 32'd1);
    repeat (10) @(posedge clk);

    // 3: 3-clk glitch on button 1 must never reach the level.
    r1 = rise_cnt[1];
    drive_at_edge(0, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    bus.btn_in = 2'b00;
    repeat (50) @(posedge clk);
    #1;
    check_eq("s3_level1", 32'(bus.btn_level[1]), 32'd0);
    check_eq("s3_no_rise", 32'(rise_cnt[1] - r1), 32'd0);

    // 4: both pressed together, repeats suppressed.
    drive_at_edge(0, 2'b11);
    push_exp(4'b0011, LAT_LO, LAT_HI, 1'b1);
    repeat (100) @(posedge clk);
    check_eq("s4_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1;
    bus.btn_in = 2'b00;
    wait_low(0, "s4_release0");
    wait_low(1, "s4_release1");
    repeat (10) @(posedge clk);

    // 5: reset while in REPEAT with the button still held.
    drive_at_edge(0, 2'b01);
    push_exp(4'b0001, LAT_LO, LAT_HI, 1'b1);
    push_exp(4'b0001, DLY * TD, DLY * TD, 1'b0);
    wait_drain(60, "s5_pre_drain");
    wait_tick_neg("s5_tick");
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("s5_async_level", 32'(lvl_all), 32'd0);
    check_eq("s5_async_pulse", 32'(pulse_all), 32'd0);
    check_eq("s5_async_tick", 32'(bus.tick), 32'd0);
    check_eq("s5_async_state", 32'(bus.chan_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stim_cyc = cyc;
    push_exp(4'b0001, LAT_LO, LAT_HI, 1'b1);
    wait_drain(30, "s5_post_drain");
    #1;
    bus.btn_in = 2'b00;
    wait_low(0, "s5_release");
    repeat (10) @(posedge clk);

    // 6: repeat disabled, one pulse per press.
    r0 = rise_cnt[2];
    drive_at_edge(1, 2'b01);
    push_exp(4'b0100, LAT_LO, LAT_HI, 1'b1);
    repeat (200) @(posedge clk);
    check_eq("s6_first_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1;
    bus_nr.btn_in = 2'b00;
    wait_low(2, "s6_release_a");
    repeat (10) @(posedge clk);
    drive_at_edge(1, 2'b01);
    push_exp(4'b0100, LAT_LO, LAT_HI, 1'b1);
    repeat (60) @(posedge clk);
    check_eq("s6_second_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1;
    bus_nr.btn_in = 2'b00;
    wait_low(2, "s6_release_b");
    check_eq("s6_level_rises", 32'(rise_cnt[2] - r0), 32'd2);
    repeat (10) @(posedge clk);

    check_eq("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
